// File: rtl/spi_slave_if.sv
// SPI slave serial front-end: deserialises 10-bit command frames to the RAM and
// serialises read data back on MISO. Optional SPI_FRAME_ERR_EN adds a frame_err pulse output.
module spi_slave_if #(
  parameter int RX_WIDTH = 10,
  parameter int TX_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                SS_n,
  input  logic                MOSI,
  output logic                MISO,
  output logic [RX_WIDTH-1:0] rx_data,
  output logic                rx_valid,
  input  logic [TX_WIDTH-1:0] tx_data,
  input  logic                tx_valid
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic                frame_err
`endif
);

  localparam int RCW = $clog2(RX_WIDTH + 1);
  localparam int TCW = $clog2(TX_WIDTH + 1);
  localparam logic [RCW-1:0] RX_LAST = RCW'(RX_WIDTH - 1);
  localparam logic [RCW-1:0] RX_FULL = RCW'(RX_WIDTH);
  localparam logic [TCW-1:0] TX_FULL = TCW'(TX_WIDTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t              state_r;
  state_t              next_s;
  logic [RCW-1:0]      rx_cnt_r;
  logic [RX_WIDTH-2:0] rx_shift_r;
  logic [TCW-1:0]      tx_cnt_r;
  logic [TX_WIDTH-1:0] tx_shift_r;
  logic                tx_busy_r;
  logic                tx_done_r;
  logic                rd_addr_seen_r;
  logic                rx_state_s;

  assign rx_state_s = (state_r == WRITE) || (state_r == READ_ADD) || (state_r == READ_DATA);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state decode; CHK_CMD consumes the route bit without storing it
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (!SS_n) next_s = CHK_CMD;
        else       next_s = IDLE;
      end
      CHK_CMD: begin
        if (SS_n)                next_s = IDLE;
        else if (!MOSI)          next_s = WRITE;
        else if (rd_addr_seen_r) next_s = READ_DATA;
        else                     next_s = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (SS_n) next_s = IDLE;
        else      next_s = state_r;
      end
      default: next_s = IDLE;
    endcase
  end

  // Receive shifter, response shifter and read-address tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt_r       <= {RCW{1'b0}};
      rx_shift_r     <= {(RX_WIDTH-1){1'b0}};
      rx_data        <= {RX_WIDTH{1'b0}};
      rx_valid       <= 1'b0;
      tx_cnt_r       <= {TCW{1'b0}};
      tx_shift_r     <= {TX_WIDTH{1'b0}};
      tx_busy_r      <= 1'b0;
      tx_done_r      <= 1'b0;
      MISO           <= 1'b0;
      rd_addr_seen_r <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (!rx_state_s || SS_n) begin
        rx_cnt_r  <= {RCW{1'b0}};
        tx_cnt_r  <= {TCW{1'b0}};
        tx_busy_r <= 1'b0;
        tx_done_r <= 1'b0;
        MISO      <= 1'b0;
      end else if (rx_cnt_r != RX_FULL) begin
        rx_shift_r <= {rx_shift_r[RX_WIDTH-3:0], MOSI};
        rx_cnt_r   <= rx_cnt_r + RCW'(1);
        if (rx_cnt_r == RX_LAST) begin
          rx_data  <= {rx_shift_r, MOSI};
          rx_valid <= 1'b1;
          if (state_r == READ_ADD) rd_addr_seen_r <= 1'b1;
        end
      end else if (state_r == READ_DATA) begin
        // Bit 7 goes out on the load edge itself, so only 7 shifts follow
        if (tx_busy_r) begin
          if (tx_cnt_r == TX_FULL) begin
            MISO           <= 1'b0;
            tx_busy_r      <= 1'b0;
            tx_done_r      <= 1'b1;
            rd_addr_seen_r <= 1'b0;
          end else begin
            MISO       <= tx_shift_r[TX_WIDTH-1];
            tx_shift_r <= {tx_shift_r[TX_WIDTH-2:0], 1'b0};
            tx_cnt_r   <= tx_cnt_r + TCW'(1);
          end
        end else if (!tx_done_r && tx_valid) begin
          MISO       <= tx_data[TX_WIDTH-1];
          tx_shift_r <= {tx_data[TX_WIDTH-2:0], 1'b0};
          tx_cnt_r   <= TCW'(1);
          tx_busy_r  <= 1'b1;
        end
      end
    end
  end

`ifdef SPI_FRAME_ERR_EN
  logic route_r;

  // Frame error pulse: early SS_n rise in receive or MISO phase, or route/word mismatch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      route_r   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (state_r == CHK_CMD) route_r <= MOSI;
      if (rx_state_s && SS_n && ((rx_cnt_r != RX_FULL) || tx_busy_r)) begin
        frame_err <= 1'b1;
      end else if (rx_state_s && !SS_n && (rx_cnt_r == RX_LAST) &&
                   (rx_shift_r[RX_WIDTH-2] != route_r)) begin
        frame_err <= 1'b1;
      end else begin
        frame_err <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// Scoreboard bench for spi_slave_if: expected command words and MISO bytes are queued
// when stimulus is driven and compared when the DUT produces them.
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
`ifdef SPI_FRAME_ERR_EN
  logic       frame_err;
  int         fe_seen = 0;
  int         fe_exp  = 0;
`endif

  int         n_cmp = 0;
  int         n_err = 0;
  bit         miso_quiet = 1'b1;
  logic [9:0] rxq[$];
  logic [7:0] txq[$];

  spi_slave_if #(.RX_WIDTH(10), .TX_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
`ifdef SPI_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: every rx_valid pulse pops one expected word; MISO idle outside responses
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        if (rxq.size() == 0) chk("rx_unexpected", 32'd1, 32'd0);
        else                 chk("rx_data", {22'd0, rx_data}, {22'd0, rxq.pop_front()});
      end
      if (miso_quiet) chk("miso_idle", {31'd0, MISO}, 32'd0);
`ifdef SPI_FRAME_ERR_EN
      if (frame_err) fe_seen++;
`endif
    end
  end

  task automatic send_frame(input logic route, input logic [9:0] bits, input int nbits,
                            input int nextra, input bit hold_ss);
    @(negedge clk); SS_n = 1'b0; MOSI = 1'b0;
    @(negedge clk); MOSI = route;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk); MOSI = bits[9-i];
    end
    if (nbits == 10) begin
      rxq.push_back(bits);
`ifdef SPI_FRAME_ERR_EN
      if (route != bits[9]) fe_exp++;
    end else begin
      fe_exp++;
`endif
    end
    for (int i = 0; i < nextra; i++) begin
      @(negedge clk); MOSI = 1'($urandom_range(0, 1));
    end
    @(negedge clk); MOSI = 1'b0;
    if (!hold_ss) begin
      SS_n = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic read_resp(input logic [7:0] d, input bit expect_out);
    logic [7:0] got;
    got = 8'd0;
    @(negedge clk); tx_data = d; tx_valid = 1'b1;
    if (expect_out) begin
      miso_quiet = 1'b0;
      txq.push_back(d);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (i == 1) tx_valid = 1'b0;
        got[7-i] = MISO;
      end
      chk("miso_byte", {24'd0, got}, {24'd0, txq.pop_front()});
      @(negedge clk);
      chk("miso_tail", {31'd0, MISO}, 32'd0);
      miso_quiet = 1'b1;
      tx_valid = 1'b1;
      repeat (3) @(negedge clk);
    end else begin
      repeat (10) @(negedge clk);
    end
    tx_valid = 1'b0; SS_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    #3;
    chk("rst_miso", {31'd0, MISO}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_rx_data", {22'd0, rx_data}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    send_frame(1'b0, 10'h0A5, 10, 0, 1'b0);
    tx_data = 8'hFF; tx_valid = 1'b1;
    send_frame(1'b0, 10'h13C, 10, 0, 1'b0);
    tx_valid = 1'b0;
    chk("rx_hold", {22'd0, rx_data}, 32'h13C);

    send_frame(1'b1, 10'h2A5, 10, 0, 1'b0);
    send_frame(1'b1, 10'h300, 10, 0, 1'b1);
    read_resp(8'hC3, 1'b1);
    send_frame(1'b1, 10'h255, 10, 0, 1'b1);
    read_resp(8'h5A, 1'b0);
    send_frame(1'b1, 10'h3FF, 10, 3, 1'b1);
    read_resp(8'h81, 1'b1);

    send_frame(1'b0, 10'h155, 6, 0, 1'b0);
    chk("abort_no_rx", {31'd0, rx_valid}, 32'd0);
    send_frame(1'b0, 10'h0F0, 10, 0, 1'b0);
    send_frame(1'b0, 10'h2A5, 10, 0, 1'b0);

    // Reset in the middle of a MISO byte
    send_frame(1'b1, 10'h211, 10, 0, 1'b0);
    send_frame(1'b1, 10'h322, 10, 0, 1'b1);
    @(negedge clk); tx_data = 8'hFF; tx_valid = 1'b1; miso_quiet = 1'b0;
    repeat (3) @(negedge clk);
    tx_valid = 1'b0;
    chk("pre_rst_miso", {31'd0, MISO}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_miso", {31'd0, MISO}, 32'd0);
    chk("mid_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("mid_rst_rx_data", {22'd0, rx_data}, 32'd0);
    @(negedge clk); SS_n = 1'b1; miso_quiet = 1'b1;
    @(negedge clk); rst_n = 1'b1;

    send_frame(1'b1, 10'h2AA, 10, 0, 1'b1);
    read_resp(8'h3C, 1'b0);
    repeat (3) @(negedge clk);

    chk("rx_queue_empty", rxq.size(), 32'd0);
`ifdef SPI_FRAME_ERR_EN
    chk("frame_err_count", fe_seen, fe_exp);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- Serial front-end of the SPI slave with single-port RAM subsystem.
- Deserialises MOSI frames into 10-bit command words for the RAM: rx_data[9:8] is the command, rx_data[7:0] is the address or data.
- Accepts the RAM's 8-bit read data with tx_valid and serialises it back on MISO.
- SPI bit clock is the system clock: one bit per clk edge while SS_n is low.

Parameters:
- RX_WIDTH, 10, width of command word sent to RAM (2 command bits + ADDR_SIZE).
- TX_WIDTH, 8, width of read data returned by RAM (equals ADDR_SIZE).

Ports:
- clk  input  1  system and SPI bit clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- SS_n  input  1  slave select, active low; frame delimiter.
- MOSI  input  1  serial data in, MSB first.
- MISO  output  1  serial read data out, MSB first.
- rx_data  output  RX_WIDTH  assembled command word to RAM.
- rx_valid  output  1  one-cycle strobe qualifying rx_data.
- tx_data  input  TX_WIDTH  read data from RAM.
- tx_valid  input  1  qualifies tx_data.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; MISO=0; rx_data=0; rx_valid=0.
  - Bit counter=0; rd_addr_seen=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n=0 sampled -> CHK_CMD.
- CHK_CMD: MOSI is sampled as the route bit (not stored).
  - route=0 -> WRITE.
  - route=1 and rd_addr_seen=0 -> READ_ADD.
  - route=1 and rd_addr_seen=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA, receive phase:
  - Shift in 10 MOSI bits MSB first, one per clk.
  - On the edge capturing bit 0: rx_data<=shifted word, and rx_valid=1 for exactly the next cycle.
  - rx_data holds its value until the next completed frame.
- WRITE: after rx_valid, remain in WRITE, idle, until SS_n=1.
- READ_ADD: on frame completion, rd_addr_seen<=1. Then idle until SS_n=1.
- READ_DATA, response phase:
  - After rx_valid, wait for tx_valid=1.
  - On that edge, load tx_data into the tx shift register.
  - On each of the next 8 edges, drive MISO with the next bit, MSB first. Bit 7 appears on MISO the cycle after tx_valid is sampled.
  - After bit 0, MISO<=0 and rd_addr_seen<=0.
  - tx_valid outside the wait window is ignored.
- Latency:
  - SS_n fall to first data bit sampled: 2 edges.
  - Last MOSI bit to rx_valid: 1 cycle.
  - tx_valid to MISO bit7: 1 cycle.
- SS_n=1 sampled in any non-IDLE state:
  - Next state IDLE; counters cleared; MISO<=0.
  - No rx_valid for a partial frame.
  - rd_addr_seen is unchanged unless that frame completed.
- Extra MOSI bits beyond 10 in a frame are ignored; no second rx_valid per frame.
- Mismatch between route bit and received rx_data[9] is not corrected; the word is forwarded as received.
- Reset asserted mid-frame: immediate return to reset values; no rx_valid is emitted.

Optional Feature:
- Macro SPI_FRAME_ERR_EN.
- Defined:
  - Adds output frame_err (1 bit, reset 0).
  - frame_err pulses 1 cycle when SS_n rises before the 10th bit of a receive phase.
  - frame_err pulses 1 cycle when SS_n rises during the 8-bit MISO phase.
  - frame_err pulses 1 cycle when the route bit differs from received rx_data[9].
  - Frame handling is otherwise identical.
- Undefined: port and logic absent; behaviour as above.

Test Plan:
- Reset: assert rst_n=0 mid-frame -> MISO=0, rx_valid=0, rx_data=0 immediately (async); state IDLE.
- Write address: SS_n low, route 0, bits 00_1010_0101 -> single rx_valid pulse with rx_data=10'h0A5; SS_n high -> IDLE.
- Write data: route 0, bits 01_0011_1100 -> rx_data=10'h13C, rx_valid one cycle; no MISO activity (stays 0).
- Read address then read data:
  - Frame 1: route 1, bits 10_1010_0101 -> rx_data=10'h2A5; rd_addr_seen=1.
  - Frame 2: route 1, bits 11_0000_0000 -> rx_data=10'h300.
  - Drive tx_data=8'hC3 with tx_valid=1 -> MISO=1,1,0,0,0,0,1,1 on 8 consecutive cycles, then 0.
- Aborted frame: SS_n high after 6 of 10 bits -> no rx_valid, next frame decodes normally; with SPI_FRAME_ERR_EN, frame_err=1 for one cycle.
- Stray tx_valid=1 while in WRITE -> MISO stays 0, no state change.
